// File: rtl/shape_processor_ctrl_writer.sv
// shape_processor_ctrl_writer: writes the CTRL SFR, reads it back and reports whether it matches the predicted value
module shape_processor_ctrl_writer #(
    parameter int                ADDR_W         = 8,
    parameter logic [ADDR_W-1:0] CTRL_ADDR      = '0,
    parameter logic [31:0]       RESET_CTRL     = 32'h0001_0000,
    parameter int                TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_shape,
    input  logic [4:0]        i_cmd_operation,
    output logic              o_bus_req,
    output logic              o_bus_write,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [31:0]       o_bus_wdata,
    input  logic [31:0]       i_bus_rdata,
    input  logic              i_bus_ack,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic              o_rsp_match,
    output logic              o_rsp_applied,
    output logic              o_rsp_timeout,
    output logic [31:0]       o_rsp_ctrl,
    output logic [31:0]       o_cur_ctrl
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] SH_RECT = 2'b01;
    localparam logic [1:0] SH_TRI = 2'b10;
    localparam logic [4:0] OP_PERIM = 5'b00000;
    localparam logic [4:0] OP_AREA = 5'b00001;
    localparam logic [4:0] OP_SQUARE = 5'b01000;
    localparam logic [4:0] OP_EQUI = 5'b10000;
    localparam logic [4:0] OP_ISO = 5'b10001;
    localparam logic [4:0] OP_KEEP = 5'b11111;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_RESP} state_t;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_wdata, r_expected, r_rsp_ctrl, r_cur;
    logic             r_applied, r_match, r_timeout;
    logic             w_last, w_legal;
    logic [1:0]       w_eff_shape;
    logic [4:0]       w_eff_op;
    logic [31:0]      w_expected;

    assign w_last = r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    assign w_eff_shape = (i_cmd_shape == 2'b00) ? r_cur[17:16] : i_cmd_shape;
    assign w_eff_op = (i_cmd_operation == OP_KEEP) ? r_cur[4:0] : i_cmd_operation;
    assign w_legal = i_cmd_shape != 2'b11
        && (i_cmd_operation inside {OP_PERIM, OP_AREA, OP_SQUARE, OP_EQUI, OP_ISO, OP_KEEP})
        && ((w_eff_op == OP_PERIM || w_eff_op == OP_AREA)
            || (w_eff_op == OP_SQUARE && w_eff_shape == SH_RECT)
            || ((w_eff_op == OP_EQUI || w_eff_op == OP_ISO) && w_eff_shape == SH_TRI));
    assign w_expected = w_legal ? {14'b0, w_eff_shape, 11'b0, w_eff_op} : r_cur;

    assign o_bus_addr = CTRL_ADDR;
    assign o_bus_wdata = r_wdata;
    assign o_rsp_match = r_match;
    assign o_rsp_applied = r_applied;
    assign o_rsp_timeout = r_timeout;
    assign o_rsp_ctrl = r_rsp_ctrl;
    assign o_cur_ctrl = r_cur;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    // next state and handshake outputs; a timeout on the write skips the read
    always_comb begin
        w_next = r_state;
        o_cmd_ready = 1'b0;
        o_bus_req = 1'b0;
        o_bus_write = 1'b0;
        o_rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) w_next = S_WRITE;
            end
            S_WRITE: begin
                o_bus_req = 1'b1;
                o_bus_write = 1'b1;
                if (i_bus_ack) w_next = S_READ;
                else if (w_last) w_next = S_RESP;
            end
            S_READ: begin
                o_bus_req = 1'b1;
                if (i_bus_ack || w_last) w_next = S_RESP;
            end
            S_RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // command latch, access timeout counter, readback capture and shadow update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_wdata <= '0;
            r_expected <= '0;
            r_rsp_ctrl <= '0;
            r_cur <= RESET_CTRL;
            r_applied <= 1'b0;
            r_match <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_cmd_valid) begin
                    r_wdata <= {14'b0, i_cmd_shape, 11'b0, i_cmd_operation};
                    r_expected <= w_expected;
                    r_applied <= w_legal && w_expected != r_cur;
                    r_match <= 1'b0;
                    r_timeout <= 1'b0;
                    r_rsp_ctrl <= '0;
                    r_cnt <= '0;
                end
                S_WRITE, S_READ: begin
                    if (i_bus_ack) begin
                        r_cnt <= '0;
                        if (r_state == S_READ) begin
                            r_rsp_ctrl <= i_bus_rdata;
                            r_match <= i_bus_rdata == r_expected;
                            r_cur <= {14'b0, i_bus_rdata[17:16], 11'b0, i_bus_rdata[4:0]};
                        end
                    end else if (w_last) begin
                        r_timeout <= 1'b1;
                        r_rsp_ctrl <= r_expected;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_shape_processor_ctrl_writer.sv
// tb_shape_processor_ctrl_writer: scoreboard bench for the CTRL writer
module tb_shape_processor_ctrl_writer;
    localparam int TO = 16;
    localparam logic [31:0] RST_CTRL = 32'h0001_0000;

    typedef struct {
        logic        match;
        logic        applied;
        logic        timeout;
        logic [31:0] ctrl;
        logic [31:0] cur;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [1:0]  cmd_shape = '0;
    logic [4:0]  cmd_operation = '0;
    logic        bus_req, bus_write, bus_ack = 1'b0;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata, bus_rdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_match, rsp_applied, rsp_timeout;
    logic [31:0] rsp_ctrl, cur_ctrl;

    rsp_t        sb[$];
    int          n_chk = 0, n_err = 0;
    logic [31:0] m_cur = RST_CTRL;

    shape_processor_ctrl_writer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_shape(cmd_shape), .i_cmd_operation(cmd_operation),
        .o_bus_req(bus_req), .o_bus_write(bus_write), .o_bus_addr(bus_addr),
        .o_bus_wdata(bus_wdata), .i_bus_rdata(bus_rdata), .i_bus_ack(bus_ack),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_match(rsp_match), .o_rsp_applied(rsp_applied),
        .o_rsp_timeout(rsp_timeout), .o_rsp_ctrl(rsp_ctrl), .o_cur_ctrl(cur_ctrl)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] predict(input logic [31:0] cur, input logic [1:0] sh, input logic [4:0] op);
        logic [1:0] s;
        logic [4:0] o;
        logic       ok;
        s = (sh == 2'd0) ? cur[17:16] : sh;
        o = (op == 5'd31) ? cur[4:0] : op;
        ok = sh != 2'd3;
        case (op)
            5'd0, 5'd1, 5'd8, 5'd16, 5'd17, 5'd31: ;
            default: ok = 1'b0;
        endcase
        case (o)
            5'd0, 5'd1: ;
            5'd8: if (s != 2'd1) ok = 1'b0;
            5'd16, 5'd17: if (s != 2'd2) ok = 1'b0;
            default: ok = 1'b0;
        endcase
        return ok ? {14'b0, s, 11'b0, o} : cur;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_cur", cur_ctrl, RST_CTRL);
        check("rst_ready", cmd_ready, 1);
        check("rst_req", {bus_req, bus_write}, 0);
        check("rst_rsp", rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_cur = RST_CTRL;
        sb.delete();
    endtask

    // one bus access; ack arrives in 0-based req cycle w (w >= TO means never)
    task automatic bus_phase(input bit wr, input int w, input logic [31:0] wd, input logic [31:0] rd);
        for (int c = 0; c < TO; c++) begin
            check(wr ? "wr_req" : "rd_req", {bus_req, bus_write}, {1'b1, wr});
            if (c == 0) check("addr", bus_addr, 0);
            if (c == 0 && wr) check("wdata", bus_wdata, wd);
            if (c == w) begin
                bus_ack = 1'b1;
                bus_rdata = rd;
                @(negedge clk);
                bus_ack = 1'b0;
                bus_rdata = $urandom;
                return;
            end
            @(negedge clk);
        end
        check("req_drop", bus_req, 0);
    endtask

    task automatic do_cmd(input logic [1:0] sh, input logic [4:0] op, input logic [31:0] rd,
                          input int ww, input int rw, input int hold);
        logic [31:0] e;
        rsp_t        x, g;
        bit          wto, rto;
        e = predict(m_cur, sh, op);
        wto = ww >= TO;
        rto = !wto && rw >= TO;
        x.timeout = wto || rto;
        x.applied = e != m_cur;
        x.match = !x.timeout && rd == e;
        x.ctrl = x.timeout ? e : rd;
        x.cur = x.timeout ? m_cur : {14'b0, rd[17:16], 11'b0, rd[4:0]};
        check("cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_shape = sh;
        cmd_operation = op;
        sb.push_back(x);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_shape = 2'($urandom);
        cmd_operation = 5'($urandom);
        bus_phase(1'b1, ww, {14'b0, sh, 11'b0, op}, '0);
        if (!wto) bus_phase(1'b0, rw, '0, rd);
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
            return;
        end
        g = sb.pop_front();
        for (int h = 0; h <= hold; h++) begin
            check("rsp_valid", rsp_valid, 1);
            check("rsp_match", rsp_match, g.match);
            check("rsp_applied", rsp_applied, g.applied);
            check("rsp_timeout", rsp_timeout, g.timeout);
            check("rsp_ctrl", rsp_ctrl, g.ctrl);
            if (h < hold) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_done", rsp_valid, 0);
        check("cur_ctrl", cur_ctrl, g.cur);
        m_cur = g.cur;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0]  ops[7] = '{5'd0, 5'd1, 5'd8, 5'd16, 5'd17, 5'd31, 5'd3};
        logic [1:0]  sh;
        logic [4:0]  op;
        logic [31:0] rd;
        do_reset();
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        check("idle_ack_req", bus_req, 0);
        check("idle_ack_rsp", rsp_valid, 0);

        do_cmd(2'b10, 5'b10001, 32'h0002_0011, 0, 0, 0);
        check("tp_tri_iso", cur_ctrl, 32'h0002_0011);
        do_reset();
        do_cmd(2'b00, 5'b01000, 32'h0001_0008, 0, 0, 0);
        do_reset();
        do_cmd(2'b10, 5'b01000, 32'h0001_0000, 0, 0, 0);
        do_cmd(2'b11, 5'b01000, 32'h0001_0000, 0, 0, 0);
        do_reset();
        do_cmd(2'b00, 5'b01000, 32'h0002_0000, 0, 0, 0);
        check("tp_mismatch", cur_ctrl, 32'h0002_0000);
        do_cmd(2'b01, 5'b00001, 32'h0001_0001, 99, 0, 5);
        do_cmd(2'b10, 5'b10000, 32'h0002_0010, 3, 15, 1);
        do_cmd(2'b01, 5'b00000, 32'h0001_0000, 0, 99, 2);
        do_cmd(2'b01, 5'b11111, 32'h0001_0000, 15, 2, 0);

        for (int i = 0; i < 10; i++) begin
            sh = 2'($urandom_range(0, 3));
            op = ops[$urandom_range(0, 6)];
            rd = ($urandom_range(0, 3) == 0) ? {14'b0, 2'($urandom), 11'b0, 5'($urandom)} : predict(m_cur, sh, op);
            do_cmd(sh, op, rd, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        do_reset();
        check("mr_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_shape = 2'b10;
        cmd_operation = 5'b10001;
        @(negedge clk);
        cmd_valid = 1'b0;
        bus_phase(1'b1, 0, 32'h0002_0011, '0);
        check("mr_read", {bus_req, bus_write}, 2'b10);
        rst_n = 1'b0;
        #1;
        check("mr_req", bus_req, 0);
        check("mr_rsp", rsp_valid, 0);
        check("mr_cur", cur_ctrl, RST_CTRL);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mr_norsp", {bus_req, rsp_valid}, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
